single_wire_initiator: RTL and testbench
========================================

# single_wire_initiator

Half-duplex initiator for the single bidirectional pad line used between icestick boards; the block is the far end of a responder that watches the pad and answers by driving it. It issues a bus reset with presence detect, writes bytes, and reads bytes using fixed-length time slots on an open-drain style line that idles released (external pull-up). It drives only `dout`/`dout_en` and samples `din`, which connect to an `SB_IO` with `PIN_TYPE` 6'b1010_01 instantiated at top level.

## Interface
- RESET_LOW, 480, cycles line held low for bus reset
- RESET_WAIT, 480, cycles released after reset low (presence window + settle)
- PRESENCE_SAMPLE, 70, cycle within RESET_WAIT at which presence is sampled
- SLOT, 64, total cycles per bit slot, excluding recovery
- BIT1_LOW, 6, low time for a written '1' and for a read slot
- READ_SAMPLE, 15, slot cycle at which a read bit is sampled
- RECOVERY, 4, released cycles between slots
- CLK  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd  in  2  0=BUS_RESET, 1=WRITE_BYTE, 2=READ_BYTE, 3=reserved (accepted, no bus activity, done pulse only)
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- wdata  in  8  byte for WRITE_BYTE, captured at accept
- rdata  out  8  byte from READ_BYTE, held until next READ_BYTE completes
- presence  out  1  presence result of last BUS_RESET
- done  out  1  one-cycle pulse at command completion
- din  in  1  pad input (asynchronous)
- dout  out  1  constant 0 (open-drain style)
- dout_en  out  1  1 = pull line low

## Operation
- Handshake: accept when `cmd_valid && cmd_ready`; cmd and wdata captured that cycle; cmd_ready drops next cycle.
- `din` passes through a 2-flop synchronizer; all sampling uses the synchronized value `din_s`.
- States: IDLE, RST_LOW, RST_WAIT, SLOT_LOW, SLOT_REL, RECOV, DONE.
- BUS_RESET: RST_LOW (dout_en=1, RESET_LOW cycles) -> RST_WAIT (dout_en=0, RESET_WAIT cycles); at wait-cycle PRESENCE_SAMPLE, presence <= ~din_s -> DONE.
- WRITE_BYTE: 8 slots LSB first. Bit '1': low BIT1_LOW cycles, released SLOT-BIT1_LOW. Bit '0': low SLOT cycles. Each slot then RECOV.
- READ_BYTE: 8 slots LSB first; low BIT1_LOW cycles, released remainder; at slot cycle READ_SAMPLE shift din_s into rdata[7] (right shift). rdata updated only at DONE (shadow shift register).
- DONE: done=1 one cycle -> IDLE.
- Slot counter counts 0..SLOT-1, bit counter 0..7; after bit 7's RECOV -> DONE.
- Counter width: $clog2 of largest of RESET_LOW, RESET_WAIT, SLOT, plus 1.

## Timing
- Reset values: cmd_ready=1 (IDLE), dout_en=0, dout=0, done=0, presence=0, rdata=8'h00.
- Reset mid-command: line released next cycle, state IDLE, captured data discarded.
- cmd_valid while busy: ignored, no queueing.
- dout_en registered: first low cycle is the cycle after accept.
- Command durations from accept to done pulse (inclusive of done cycle): BUS_RESET = RESET_LOW+RESET_WAIT+1; byte = 8*(SLOT+RECOVERY)+1.
- Sampling includes synchronizer delay: read sample sees the pad 2 cycles before the sample cycle.
- Parameter legality (checked at elaboration): BIT1_LOW < READ_SAMPLE < SLOT; PRESENCE_SAMPLE < RESET_WAIT; all >= 1.

## Structure
- Package `single_wire_pkg`: cmd encoding constants, state enum.
- Sub-module `sync2`: 2-flop synchronizer for din (reset to 1, line idle value).
- Counters and FSM in top of block; no SB_IO inside.

## Test plan
- BUS_RESET, model responder pulls low cycles 500..600 after accept -> dout_en high exactly 480 cycles, presence=1, done at cycle 961.
- BUS_RESET with no responder (line released) -> presence=0, same duration.
- WRITE_BYTE wdata=8'hA5 -> slot low times LSB first 6,64,6,64,64,6,64,6 cycles; done after 545 cycles.
- READ_BYTE, model drives 8'h3C (holds low through sample for '0' bits) -> rdata=8'h3C at done, unchanged by a later WRITE_BYTE.
- cmd_valid held during busy, then reset asserted mid-slot -> no second command accepted; dout_en=0 and cmd_ready=1 the cycle after reset.
- cmd=3 -> no dout_en activity, done pulse 2 cycles after accept.

Source files
------------

// File: rtl/single_wire_pkg.sv
// Shared encodings for the single-wire initiator: command codes, FSM states,
// default slot timing and a small helper for sizing the shared counter.
package single_wire_pkg;

    localparam logic [1:0] CMD_BUS_RESET  = 2'd0;
    localparam logic [1:0] CMD_WRITE_BYTE = 2'd1;
    localparam logic [1:0] CMD_READ_BYTE  = 2'd2;
    localparam logic [1:0] CMD_RESERVED   = 2'd3;

    localparam int DEF_RESET_LOW       = 480;
    localparam int DEF_RESET_WAIT      = 480;
    localparam int DEF_PRESENCE_SAMPLE = 70;
    localparam int DEF_SLOT            = 64;
    localparam int DEF_BIT1_LOW        = 6;
    localparam int DEF_READ_SAMPLE     = 15;
    localparam int DEF_RECOVERY        = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_LOW,
        ST_RST_WAIT,
        ST_SLOT_LOW,
        ST_SLOT_REL,
        ST_RECOV,
        ST_DONE
    } state_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/single_wire_initiator_sync2.sv
// Two-flop synchronizer for the asynchronous pad input. Resets to 1, the
// value of the released (pulled-up) line, so reset never looks like a pull.
module single_wire_initiator_sync2 (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Double-register the pad to resolve metastability.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/single_wire_initiator.sv
// Half-duplex single-wire initiator: bus reset with presence detect, byte
// write and byte read using fixed-length slots on an open-drain style line.
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_IDLE     | released, cmd_ready high, waiting for a command
// ST_RST_LOW  | bus reset, line held low for RESET_LOW cycles
// ST_RST_WAIT | line released, presence sampled at PRESENCE_SAMPLE
// ST_SLOT_LOW | low part of a bit slot (BIT1_LOW, or whole SLOT for a '0')
// ST_SLOT_REL | released rest of a slot; read bits sampled here
// ST_RECOV    | released recovery gap after every slot
// ST_DONE     | one-cycle done pulse, then back to idle
module single_wire_initiator
    import single_wire_pkg::*;
#(
    parameter int RESET_LOW       = DEF_RESET_LOW,
    parameter int RESET_WAIT      = DEF_RESET_WAIT,
    parameter int PRESENCE_SAMPLE = DEF_PRESENCE_SAMPLE,
    parameter int SLOT            = DEF_SLOT,
    parameter int BIT1_LOW        = DEF_BIT1_LOW,
    parameter int READ_SAMPLE     = DEF_READ_SAMPLE,
    parameter int RECOVERY        = DEF_RECOVERY
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [1:0] i_cmd,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic [7:0] i_wdata,
    output logic [7:0] o_rdata,
    output logic       o_presence,
    output logic       o_done,
    input  logic       i_din,
    output logic       o_dout,
    output logic       o_dout_en
);

    // Recovery reuses the slot counter, so it takes part in the sizing too.
    localparam int CNT_W = $clog2(max4(RESET_LOW, RESET_WAIT, SLOT, RECOVERY)) + 1;

    localparam logic [CNT_W-1:0] C_RST_LOW_END  = CNT_W'(RESET_LOW - 1);
    localparam logic [CNT_W-1:0] C_RST_WAIT_END = CNT_W'(RESET_WAIT - 1);
    localparam logic [CNT_W-1:0] C_PRESENCE     = CNT_W'(PRESENCE_SAMPLE);
    localparam logic [CNT_W-1:0] C_SLOT_END     = CNT_W'(SLOT - 1);
    localparam logic [CNT_W-1:0] C_BIT1_END     = CNT_W'(BIT1_LOW - 1);
    localparam logic [CNT_W-1:0] C_READ_SAMPLE  = CNT_W'(READ_SAMPLE);
    localparam logic [CNT_W-1:0] C_RECOV_END    = CNT_W'(RECOVERY - 1);

    if (!(BIT1_LOW >= 1 && BIT1_LOW < READ_SAMPLE && READ_SAMPLE < SLOT)) begin : g_bad_slot
        $error("single_wire_initiator: need 1 <= BIT1_LOW < READ_SAMPLE < SLOT");
    end
    if (!(PRESENCE_SAMPLE >= 1 && PRESENCE_SAMPLE < RESET_WAIT)) begin : g_bad_presence
        $error("single_wire_initiator: need 1 <= PRESENCE_SAMPLE < RESET_WAIT");
    end
    if (!(RESET_LOW >= 1 && RECOVERY >= 1)) begin : g_bad_len
        $error("single_wire_initiator: RESET_LOW and RECOVERY must be >= 1");
    end

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [1:0]       r_cmd;
    logic [7:0]       r_wshift;
    logic [7:0]       r_rshift;
    logic [7:0]       r_rdata;
    logic             r_presence;
    logic             r_done;
    logic             r_dout_en;
    logic             r_cmd_ready;
    logic             w_din_s;
    logic             w_short_low;

    single_wire_initiator_sync2 u_sync2 (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_din),
        .o_q     (w_din_s)
    );

    // Read slots and written '1's release after BIT1_LOW; written '0's hold the whole slot.
    assign w_short_low = (r_cmd == CMD_READ_BYTE) || r_wshift[0];

    // Command FSM with registered line drive, handshake and result outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_cmd       <= CMD_BUS_RESET;
            r_wshift    <= '0;
            r_rshift    <= '0;
            r_rdata     <= '0;
            r_presence  <= 1'b0;
            r_done      <= 1'b0;
            r_dout_en   <= 1'b0;
            r_cmd_ready <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_cmd_valid && r_cmd_ready) begin
                        r_cmd       <= i_cmd;
                        r_wshift    <= i_wdata;
                        r_cnt       <= '0;
                        r_bit       <= '0;
                        r_cmd_ready <= 1'b0;
                        case (i_cmd)
                            CMD_BUS_RESET: begin
                                r_state   <= ST_RST_LOW;
                                r_dout_en <= 1'b1;
                            end
                            CMD_WRITE_BYTE, CMD_READ_BYTE: begin
                                r_state   <= ST_SLOT_LOW;
                                r_dout_en <= 1'b1;
                            end
                            default: begin
                                // Reserved: one released turnaround cycle through the
                                // last recovery step, then the done pulse.
                                r_state <= ST_RECOV;
                                r_cnt   <= C_RECOV_END;
                                r_bit   <= 3'd7;
                            end
                        endcase
                    end
                end
                ST_RST_LOW: begin
                    if (r_cnt == C_RST_LOW_END) begin
                        r_state   <= ST_RST_WAIT;
                        r_cnt     <= '0;
                        r_dout_en <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RST_WAIT: begin
                    if (r_cnt == C_PRESENCE) begin
                        r_presence <= ~w_din_s;
                    end
                    if (r_cnt == C_RST_WAIT_END) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_SLOT_LOW: begin
                    if (w_short_low && r_cnt == C_BIT1_END) begin
                        r_state   <= ST_SLOT_REL;
                        r_dout_en <= 1'b0;
                        r_cnt     <= r_cnt + 1'b1;
                    end else if (r_cnt == C_SLOT_END) begin
                        r_state   <= ST_RECOV;
                        r_dout_en <= 1'b0;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_SLOT_REL: begin
                    if (r_cmd == CMD_READ_BYTE && r_cnt == C_READ_SAMPLE) begin
                        r_rshift <= {w_din_s, r_rshift[7:1]};
                    end
                    if (r_cnt == C_SLOT_END) begin
                        r_state <= ST_RECOV;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RECOV: begin
                    if (r_cnt == C_RECOV_END) begin
                        r_cnt <= '0;
                        if (r_bit == 3'd7) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            if (r_cmd == CMD_READ_BYTE) begin
                                r_rdata <= r_rshift;
                            end
                        end else begin
                            r_state   <= ST_SLOT_LOW;
                            r_dout_en <= 1'b1;
                            r_bit     <= r_bit + 1'b1;
                            r_wshift  <= {1'b0, r_wshift[7:1]};
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    r_cmd_ready <= 1'b1;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_dout_en   <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_cmd_ready = r_cmd_ready;
    assign o_rdata     = r_rdata;
    assign o_presence  = r_presence;
    assign o_done      = r_done;
    assign o_dout      = 1'b0;
    assign o_dout_en   = r_dout_en;

endmodule

// File: tb/tb_single_wire_initiator.sv
// Directed bench for single_wire_initiator: a table of commands with
// hand-computed durations, low-time totals and results, plus sequences for
// per-slot low times and reset in the middle of a busy command.
module tb_single_wire_initiator;

    localparam int M_NONE   = 0;
    localparam int M_PRES   = 1;
    localparam int M_READ   = 2;
    localparam int BUDGET   = 1200;
    localparam int SLOT_LEN = 68;

    typedef struct {
        logic [1:0] cmd;
        logic [7:0] wdata;
        int         mode;
        logic [7:0] resp;
        int         exp_dur;
        int         exp_lows;
        logic       exp_pres;
        logic [7:0] exp_rdata;
    } vec_t;

    logic       clk;
    logic       i_reset;
    logic [1:0] i_cmd;
    logic       i_cmd_valid;
    logic       o_cmd_ready;
    logic [7:0] i_wdata;
    logic [7:0] o_rdata;
    logic       o_presence;
    logic       o_done;
    logic       i_din;
    logic       o_dout;
    logic       o_dout_en;

    int   n_vec;
    int   n_err;
    int   runs[$];
    vec_t vecs[9];

    single_wire_initiator dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_cmd       (i_cmd),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_wdata     (i_wdata),
        .o_rdata     (o_rdata),
        .o_presence  (o_presence),
        .o_done      (o_done),
        .i_din       (i_din),
        .o_dout      (o_dout),
        .o_dout_en   (o_dout_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Responder model: does the far end pull the line in cycle n after accept?
    function automatic bit resp_pull(input int mode, input logic [7:0] rb, input int n);
        int i;
        int s;
        if (mode == M_PRES) return (n >= 500 && n <= 600);
        if (mode == M_READ && n >= 1) begin
            i = (n - 1) / SLOT_LEN;
            s = (n - 1) % SLOT_LEN;
            if (i > 7) return 1'b0;
            return (rb[i] == 1'b0) && (s <= 30);
        end
        return 1'b0;
    endfunction

    // Issue one command and watch it to completion; cycle n is the n-th cycle after accept.
    task automatic run_cmd(input logic [1:0] c, input logic [7:0] wd, input int mode,
                           input logic [7:0] rb, output int dur, output int lows,
                           output int rdy_busy, output logic post_done, output logic post_ready);
        int run;
        runs.delete();
        dur = 0;
        lows = 0;
        rdy_busy = 0;
        run = 0;
        @(negedge clk);
        i_cmd = c;
        i_wdata = wd;
        i_cmd_valid = 1'b1;
        for (int n = 1; n <= BUDGET; n++) begin
            @(negedge clk);
            if (n == 1) i_cmd_valid = 1'b0;
            i_din = !o_dout_en && !resp_pull(mode, rb, n);
            if (o_dout_en) begin
                lows++;
                run++;
            end else if (run > 0) begin
                runs.push_back(run);
                run = 0;
            end
            if (o_done) begin
                dur = n;
                break;
            end
            if (o_cmd_ready) rdy_busy++;
        end
        @(negedge clk);
        i_din = 1'b1;
        post_done = o_done;
        post_ready = o_cmd_ready;
    endtask

    initial begin
        int   dur;
        int   lows;
        int   rdy;
        logic pdone;
        logic prdy;
        int   exp_runs[8];

        n_vec = 0;
        n_err = 0;
        i_reset = 1'b1;
        i_cmd = 2'd0;
        i_cmd_valid = 1'b0;
        i_wdata = 8'h00;
        i_din = 1'b1;

        vecs[0] = '{2'd0, 8'h00, M_PRES, 8'h00, 961, 480, 1'b1, 8'h00};
        vecs[1] = '{2'd0, 8'h00, M_NONE, 8'h00, 961, 480, 1'b0, 8'h00};
        vecs[2] = '{2'd1, 8'hA5, M_NONE, 8'h00, 545, 280, 1'b0, 8'h00};
        vecs[3] = '{2'd2, 8'h00, M_READ, 8'h3C, 545,  48, 1'b0, 8'h3C};
        vecs[4] = '{2'd1, 8'hFF, M_NONE, 8'h00, 545,  48, 1'b0, 8'h3C};
        vecs[5] = '{2'd1, 8'h00, M_NONE, 8'h00, 545, 512, 1'b0, 8'h3C};
        vecs[6] = '{2'd3, 8'h5A, M_NONE, 8'h00,   2,   0, 1'b0, 8'h3C};
        vecs[7] = '{2'd2, 8'h00, M_READ, 8'h81, 545,  48, 1'b0, 8'h81};
        vecs[8] = '{2'd0, 8'h00, M_PRES, 8'h00, 961, 480, 1'b1, 8'h81};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", o_cmd_ready, 1);
        check("rst_dout_en",   o_dout_en,   0);
        check("rst_dout",      o_dout,      0);
        check("rst_done",      o_done,      0);
        check("rst_presence",  o_presence,  0);
        check("rst_rdata",     o_rdata,     8'h00);
        i_reset = 1'b0;

        for (int v = 0; v < 9; v++) begin
            run_cmd(vecs[v].cmd, vecs[v].wdata, vecs[v].mode, vecs[v].resp,
                    dur, lows, rdy, pdone, prdy);
            check($sformatf("v%0d_duration", v),   dur,        vecs[v].exp_dur);
            check($sformatf("v%0d_low_cycles", v), lows,       vecs[v].exp_lows);
            check($sformatf("v%0d_presence", v),   o_presence, vecs[v].exp_pres);
            check($sformatf("v%0d_rdata", v),      o_rdata,    vecs[v].exp_rdata);
            check($sformatf("v%0d_ready_busy", v), rdy,        0);
            check($sformatf("v%0d_done_width", v), pdone,      0);
            check($sformatf("v%0d_ready_after", v), prdy,      1);
        end

        // Per-slot low times for 8'hA5, LSB first.
        exp_runs = '{6, 64, 6, 64, 64, 6, 64, 6};
        run_cmd(2'd1, 8'hA5, M_NONE, 8'h00, dur, lows, rdy, pdone, prdy);
        check("a5_run_count", runs.size(), 8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("a5_slot%0d_low", k), (k < runs.size()) ? runs[k] : -1, exp_runs[k]);
        end

        // cmd_valid held while busy, then reset in the middle of slot 1 (a '0' bit).
        @(negedge clk);
        i_cmd = 2'd1;
        i_wdata = 8'h00;
        i_cmd_valid = 1'b1;
        rdy = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            i_din = !o_dout_en;
            if (o_cmd_ready) rdy++;
        end
        check("busy_ready_seen", rdy, 0);
        check("busy_mid_slot_low", o_dout_en, 1);
        i_reset = 1'b1;
        i_cmd_valid = 1'b0;
        @(negedge clk);
        i_din = 1'b1;
        check("midrst_dout_en",   o_dout_en,   0);
        check("midrst_cmd_ready", o_cmd_ready, 1);
        check("midrst_rdata",     o_rdata,     8'h00);
        check("midrst_presence",  o_presence,  0);
        i_reset = 1'b0;
        lows = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (o_dout_en || o_done) lows++;
        end
        check("post_reset_quiet", lows, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
